// File: rtl/uart_word_link.sv
// uart_word_link: parametrised UART word transceiver.
// TX serialises an 8*WORD_BYTES-bit word into back-to-back 8N1 frames,
// LSB byte first. RX rebuilds words from incoming frames, flags framing
// errors and drops partial words after an idle timeout.
// Optional build macro UART_PARITY_EN: adds an even-parity bit between the
// data and stop bits on both paths, plus the rx_parity_err strobe port.
module uart_word_link #(
  parameter int CLKS_PER_BIT    = 27,
  parameter int WORD_BYTES      = 4,
  parameter int STOP_BITS       = 1,
  parameter int RX_TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] i_sys_data,
  input  logic                    sys_tx_data_valid,
  output logic                    word_busy,
  output logic                    uart_tx,
  input  logic                    uart_rx,
  output logic [8*WORD_BYTES-1:0] o_sys_data,
  output logic                    sys_rx_data_valid,
  output logic                    rx_frame_err,
  output logic                    rx_timeout
`ifdef UART_PARITY_EN
  ,
  output logic                    rx_parity_err
`endif
);

  localparam int W         = 8 * WORD_BYTES;
  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int BW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_CYCLES = RX_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);
  localparam logic [0:0]    STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

`ifdef UART_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t      tx_state, tx_state_next;
  logic [CW-1:0]  tx_clk;
  logic [2:0]     tx_bit;
  logic [2:0]     tx_bit_inc;
  logic [0:0]     tx_stop;
  logic [BW-1:0]  tx_byte;
  logic [W-1:0]   tx_word;   // current byte always sits in tx_word[7:0]
  logic           tx_tick;

  assign tx_tick    = (tx_clk == BIT_LAST);
  assign tx_bit_inc = tx_bit + 3'd1;
  assign word_busy  = (tx_state != TX_IDLE);

  // TX state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_next;
  end

  // TX next-state: one frame per byte, no gap between frames.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (sys_tx_data_valid) tx_state_next = TX_START;
      TX_START:  if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA:   if (tx_tick && tx_bit == 3'd7)
                   tx_state_next = PARITY_EN ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tick) tx_state_next = TX_STOP;
      TX_STOP:   if (tx_tick && tx_stop == STOP_LAST)
                   tx_state_next = (tx_byte == BYTE_LAST) ? TX_IDLE : TX_START;
      default:   tx_state_next = TX_IDLE;
    endcase
  end

  // TX datapath: bit timer, word latch and registered line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx <= 1'b1;
      tx_clk  <= '0;
      tx_bit  <= '0;
      tx_stop <= '0;
      tx_byte <= '0;
      tx_word <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_clk <= '0;
      else                                tx_clk <= tx_clk + 1'b1;

      case (tx_state)
        TX_IDLE: if (sys_tx_data_valid) begin
          tx_word <= i_sys_data;
          tx_byte <= '0;
          uart_tx <= 1'b0;
        end
        TX_START: if (tx_tick) uart_tx <= tx_word[0];
        TX_DATA: if (tx_tick) begin
          tx_bit <= tx_bit_inc;
          if (tx_bit == 3'd7) uart_tx <= PARITY_EN ? ^tx_word[7:0] : 1'b1;
          else                uart_tx <= tx_word[tx_bit_inc];
        end
        TX_PARITY: if (tx_tick) uart_tx <= 1'b1;
        TX_STOP: if (tx_tick) begin
          if (tx_stop == STOP_LAST) begin
            tx_stop <= '0;
            if (tx_byte != BYTE_LAST) begin
              tx_byte <= tx_byte + 1'b1;
              tx_word <= tx_word >> 8;
              uart_tx <= 1'b0;
            end
          end else begin
            tx_stop <= tx_stop + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic           rx_meta, rx_sync, rx_prev;
  logic           rx_fall;
  rx_state_t      rx_state, rx_state_next;
  logic [CW-1:0]  rx_clk;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift;
  logic [BW-1:0]  rx_k;
  logic [W-1:0]   rx_buf;
  logic [W-1:0]   rx_word_next;
  logic [TW-1:0]  rx_to_cnt;
  logic           rx_tick;
  logic           rx_par_bad;

  assign rx_fall    = rx_prev & ~rx_sync;
  assign rx_tick    = (rx_clk == BIT_LAST);
  assign rx_par_bad = (rx_state == RX_PARITY) && rx_tick && (rx_sync != ^rx_shift);

  // Synchroniser for the asynchronous serial input plus edge-detect history.
  always_ff @(posedge clk) begin
    // NOTE: two flops before any use of uart_rx; preset high so reset does
    // not look like a start bit.
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_next;
  end

  // RX next-state: half-bit start qualification, then full-bit samples.
  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_state_next = RX_START;
      RX_START:  if (rx_clk == HALF_BIT)
                   rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && rx_bit == 3'd7)
                   rx_state_next = PARITY_EN ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_state_next = rx_par_bad ? RX_BREAK : RX_STOP;
      RX_STOP:   if (rx_tick) rx_state_next = rx_sync ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (rx_sync) rx_state_next = RX_IDLE;
      default:   rx_state_next = RX_IDLE;
    endcase
  end

  // Word being assembled with the just-received byte dropped into lane k.
  always_comb begin
    rx_word_next = rx_buf;
    rx_word_next[{rx_k, 3'b000} +: 8] = rx_shift;
  end

  // RX datapath: bit timer, shifter, lane assembly, strobes and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_clk            <= '0;
      rx_bit            <= '0;
      rx_shift          <= '0;
      rx_k              <= '0;
      rx_buf            <= '0;
      rx_to_cnt         <= '0;
      o_sys_data        <= '0;
      sys_rx_data_valid <= 1'b0;
      rx_frame_err      <= 1'b0;
      rx_timeout        <= 1'b0;
    end else begin
      sys_rx_data_valid <= 1'b0;
      rx_frame_err      <= 1'b0;
      rx_timeout        <= 1'b0;

      if (rx_state == RX_IDLE || rx_state_next != rx_state || rx_tick) rx_clk <= '0;
      else                                                             rx_clk <= rx_clk + 1'b1;

      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end

      if (rx_state == RX_STOP && rx_tick) begin
        if (rx_sync) begin
          if (rx_k == BYTE_LAST) begin
            o_sys_data        <= rx_word_next;
            sys_rx_data_valid <= 1'b1;
            rx_k              <= '0;
          end else begin
            rx_buf <= rx_word_next;
            rx_k   <= rx_k + 1'b1;
          end
        end else begin
          rx_frame_err <= 1'b1;
          rx_k         <= '0;
        end
      end

      if (rx_par_bad) rx_k <= '0;

      // Idle timer only runs while a partial word is pending.
      if (rx_state != RX_IDLE || rx_k == '0) begin
        rx_to_cnt <= '0;
      end else if (rx_to_cnt == TO_LAST) begin
        rx_timeout <= 1'b1;
        rx_k       <= '0;
        rx_to_cnt  <= '0;
      end else begin
        rx_to_cnt <= rx_to_cnt + 1'b1;
      end
    end
  end

`ifdef UART_PARITY_EN
  // Parity error strobe, one cycle per rejected byte.
  always_ff @(posedge clk) begin
    if (rst) rx_parity_err <= 1'b0;
    else     rx_parity_err <= rx_par_bad;
  end
`endif

endmodule
